// File: rtl/pipe_pkg.sv
// Shared definitions for the ALU-pipeline issuer: opcodes, instruction layout
// and the per-opcode source-operand usage rules.
package pipe_pkg;

  localparam int INSTR_W  = 24;
  localparam int FUNC_LSB = 20;
  localparam int RS1_LSB  = 16;
  localparam int RS2_LSB  = 12;
  localparam int RD_LSB   = 8;
  localparam int ADDR_LSB = 0;

  localparam logic [3:0] F_ADD  = 4'd0;
  localparam logic [3:0] F_SUB  = 4'd1;
  localparam logic [3:0] F_MUL  = 4'd2;
  localparam logic [3:0] F_SELA = 4'd3;
  localparam logic [3:0] F_SELB = 4'd4;
  localparam logic [3:0] F_AND  = 4'd5;
  localparam logic [3:0] F_OR   = 4'd6;
  localparam logic [3:0] F_XOR  = 4'd7;
  localparam logic [3:0] F_NEGA = 4'd8;
  localparam logic [3:0] F_NEGB = 4'd9;
  localparam logic [3:0] F_SRA  = 4'd10;
  localparam logic [3:0] F_SLA  = 4'd11;

  typedef struct packed {
    logic [3:0] func;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [3:0] rd;
    logic [7:0] addr;
  } instr_t;

  typedef struct packed {
    logic       v;
    logic [3:0] rd;
  } sb_entry_t;

  // Reserved opcodes read no operands, so they can never be held back.
  function automatic logic uses_a(input logic [3:0] func);
    case (func)
      F_ADD, F_SUB, F_MUL, F_SELA, F_AND, F_OR,
      F_XOR, F_NEGA, F_SRA, F_SLA: uses_a = 1'b1;
      F_SELB, F_NEGB:              uses_a = 1'b0;
      default:                     uses_a = 1'b0;
    endcase
  endfunction

  function automatic logic uses_b(input logic [3:0] func);
    case (func)
      F_ADD, F_SUB, F_MUL, F_AND, F_OR, F_XOR: uses_b = 1'b1;
      default:                                 uses_b = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_issue_if.sv
// Handshake bundles around the issuer: the incoming instruction stream and
// the issued-instruction bus towards the ALU pipeline.
interface instr_if;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_instr;

  modport master (output in_valid, output in_instr, input in_ready);
  modport slave  (input in_valid, input in_instr, output in_ready);
endinterface

interface pipe_if;
  logic       pipe_valid;
  logic [3:0] rs1;
  logic [3:0] rs2;
  logic [3:0] rd;
  logic [3:0] func;
  logic [7:0] addr;

  modport master (output pipe_valid, output rs1, output rs2, output rd,
                  output func, output addr);
  modport slave  (input pipe_valid, input rs1, input rs2, input rd,
                  input func, input addr);
endinterface

// File: rtl/pipe_scoreboard.sv
// In-flight destination tracker: a DEPTH-deep {v,rd} shift register and the
// RAW compare of the candidate instruction's sources against it.
module pipe_scoreboard
  import pipe_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic [3:0] i_push_rd,
  input  logic [3:0] i_func,
  input  logic [3:0] i_rs1,
  input  logic [3:0] i_rs2,
  output logic       o_hazard
);

  sb_entry_t r_sb [DEPTH];
  logic      w_use_a;
  logic      w_use_b;

  assign w_use_a = uses_a(i_func);
  assign w_use_b = uses_b(i_func);

  // Shift every cycle; a non-accept still advances the window with an empty slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_sb[i] <= '0;
      end
    end else begin
      r_sb[0].v  <= i_push;
      r_sb[0].rd <= i_push ? i_push_rd : 4'd0;
      for (int i = 1; i < DEPTH; i++) begin
        r_sb[i] <= r_sb[i-1];
      end
    end
  end

  // Compare sources against every still-valid in-flight destination.
  always_comb begin
    o_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      o_hazard = o_hazard | (r_sb[i].v &
                 ((w_use_a & (i_rs1 == r_sb[i].rd)) |
                  (w_use_b & (i_rs2 == r_sb[i].rd))));
    end
  end

endmodule

// File: rtl/pipe_issue.sv
// Instruction issuer: accepts packed instructions, holds them back on RAW
// hazards and drives one registered instruction (or bubble) per cycle.
module pipe_issue
  import pipe_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  instr_if.slave           s_in,
  pipe_if.master           m_pipe,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  instr_t           w_instr;
  logic             w_hazard;
  logic             w_ready;
  logic             w_accept;
  logic             w_stall;
  logic             r_valid;
  instr_t           r_instr;
  logic [CNT_W-1:0] r_issue_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_instr  = instr_t'(s_in.in_instr);
  assign w_ready  = !rst && !w_hazard;
  assign w_accept = s_in.in_valid && w_ready;
  assign w_stall  = s_in.in_valid && !w_ready;

  assign s_in.in_ready = w_ready;

  pipe_scoreboard #(.DEPTH(DEPTH)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_accept),
    .i_push_rd (w_instr.rd),
    .i_func    (w_instr.func),
    .i_rs1     (w_instr.rs1),
    .i_rs2     (w_instr.rs2),
    .o_hazard  (w_hazard)
  );

  // Output register: bubbles carry all-zero fields so downstream sees no stale data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_instr     <= '0;
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_valid <= w_accept;
      r_instr <= w_accept ? w_instr : '0;
      if (w_accept) begin
        r_issue_cnt <= r_issue_cnt + CNT_W'(1);
      end else begin
        r_issue_cnt <= r_issue_cnt;
      end
      if (w_stall) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
    end
  end

  assign m_pipe.pipe_valid = r_valid;
  assign m_pipe.func       = r_instr.func;
  assign m_pipe.rs1        = r_instr.rs1;
  assign m_pipe.rs2        = r_instr.rs2;
  assign m_pipe.rd         = r_instr.rd;
  assign m_pipe.addr       = r_instr.addr;
  assign issue_cnt         = r_issue_cnt;
  assign stall_cnt         = r_stall_cnt;

endmodule

// File: tb/tb_pipe_issue.sv
// Self-checking bench for pipe_issue: directed hazard scenarios plus random
// traffic against a timestamp-based hazard model and an expected-issue queue.
module tb_pipe_issue;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] issue_cnt;
  logic [15:0] stall_cnt;

  instr_if u_in ();
  pipe_if  u_out ();

  pipe_issue #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_in      (u_in),
    .m_pipe    (u_out),
    .issue_cnt (issue_cnt),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] ins;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          last_wr[16];
  logic [15:0] cur_issue = 16'd0, cur_stall = 16'd0;
  logic [15:0] nxt_issue = 16'd0, nxt_stall = 16'd0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit ref_hazard(input int f, input int a, input int b);
    bit ua, ub;
    ua = (f < 12) && (f != 4) && (f != 9);
    ub = (f == 0) || (f == 1) || (f == 2) || (f == 5) || (f == 6) || (f == 7);
    return (ua && (cyc - last_wr[a] <= DEPTH)) || (ub && (cyc - last_wr[b] <= DEPTH));
  endfunction

  task automatic clear_model();
    for (int r = 0; r < 16; r++) last_wr[r] = -100;
  endtask

  // Entered at posedge+1 with inputs set; returns at the next posedge+1.
  task automatic do_cycle(output bit acc);
    bit          rdy;
    logic [23:0] ins;
    #2;
    ins = u_in.in_instr;
    rdy = !rst && !ref_hazard(int'(ins[23:20]), int'(ins[19:16]), int'(ins[15:12]));
    chk(u_in.in_ready === rdy, "in_ready", 32'(u_in.in_ready), 32'(rdy));
    acc = u_in.in_valid && rdy;
    if (rst) begin
      clear_model();
      nxt_issue = 16'd0;
      nxt_stall = 16'd0;
    end else begin
      nxt_issue = cur_issue;
      nxt_stall = cur_stall;
      if (acc) begin
        q.push_back('{ins, cyc + 1});
        last_wr[int'(ins[11:8])] = cyc;
        nxt_issue = cur_issue + 16'd1;
      end
      if (u_in.in_valid && !rdy) nxt_stall = cur_stall + 16'd1;
    end
    @(posedge clk);
    cyc++;
    cur_issue = nxt_issue;
    cur_stall = nxt_stall;
    #1;
  endtask

  task automatic send(input logic [23:0] ins, output int stalls);
    bit acc;
    u_in.in_valid = 1'b1;
    u_in.in_instr = ins;
    stalls = 0;
    acc = 1'b0;
    while (!acc && stalls <= 8) begin
      do_cycle(acc);
      if (!acc) stalls++;
    end
    if (!acc) chk(1'b0, "send_timeout", 32'(stalls), 32'd0);
  endtask

  task automatic idle(input int n);
    bit acc;
    u_in.in_valid = 1'b0;
    repeat (n) do_cycle(acc);
  endtask

  function automatic logic [23:0] mk(input int f, input int a, input int b, input int d, input int ad);
    return {4'(f), 4'(a), 4'(b), 4'(d), 8'(ad)};
  endfunction

  // Monitor: pops an expectation whenever the DUT presents an instruction.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (cyc > 0) begin
      if (u_out.pipe_valid === 1'b1) begin
        if (q.size() == 0) begin
          chk(1'b0, "unexpected_issue", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk(e.cyc == cyc, "issue_latency", 32'(cyc), 32'(e.cyc));
          chk({u_out.func, u_out.rs1, u_out.rs2, u_out.rd, u_out.addr} === e.ins, "issue_fields",
              32'({u_out.func, u_out.rs1, u_out.rs2, u_out.rd, u_out.addr}), 32'(e.ins));
        end
      end else begin
        chk(u_out.pipe_valid === 1'b0, "pipe_valid_known", 32'(u_out.pipe_valid), 32'd0);
        chk({u_out.func, u_out.rs1, u_out.rs2, u_out.rd, u_out.addr} === 24'd0, "bubble_fields",
            32'({u_out.func, u_out.rs1, u_out.rs2, u_out.rd, u_out.addr}), 32'd0);
        if (q.size() > 0 && q[0].cyc <= cyc) begin
          chk(1'b0, "missing_issue", 32'(cyc), 32'(q[0].cyc));
          void'(q.pop_front());
        end
      end
      chk(issue_cnt === cur_issue, "issue_cnt", 32'(issue_cnt), 32'(cur_issue));
      chk(stall_cnt === cur_stall, "stall_cnt", 32'(stall_cnt), 32'(cur_stall));
    end
  end

  initial begin : driver
    int          st;
    bit          acc;
    bit          pend;
    clear_model();
    rst           = 1'b1;
    u_in.in_valid = 1'b1;
    u_in.in_instr = mk(0, 1, 2, 3, 8'h11);
    repeat (3) do_cycle(acc);
    rst = 1'b0;
    idle(2);

    // Independent stream issues back to back.
    send(mk(0, 3, 5, 10, 8'h40), st); chk(st == 0, "indep_add", 32'(st), 32'd0);
    send(mk(2, 3, 8, 12, 8'h41), st); chk(st == 0, "indep_mul", 32'(st), 32'd0);
    send(mk(1, 1, 2, 14, 8'h42), st); chk(st == 0, "indep_sub", 32'(st), 32'd0);
    idle(3);
    chk(issue_cnt === 16'd3, "indep_issue_cnt", 32'(issue_cnt), 32'd3);
    chk(stall_cnt === 16'd0, "indep_stall_cnt", 32'(stall_cnt), 32'd0);

    // RAW on rs1: two stall cycles.
    send(mk(0, 1, 2, 10, 8'h50), st);
    send(mk(1, 10, 5, 11, 8'h51), st); chk(st == 2, "raw_stalls", 32'(st), 32'd2);
    idle(3);
    chk(stall_cnt === 16'd2, "raw_stall_cnt", 32'(stall_cnt), 32'd2);

    // SELB ignores rs1.
    send(mk(0, 1, 2, 7, 8'h60), st);
    send(mk(4, 7, 3, 8, 8'h61), st); chk(st == 0, "selb_no_hazard", 32'(st), 32'd0);
    idle(3);

    // Producer two slots back: one stall only.
    send(mk(0, 1, 2, 12, 8'h70), st);
    send(mk(7, 4, 5, 13, 8'h71), st);
    send(mk(0, 6, 12, 15, 8'h72), st); chk(st == 1, "dist2_stalls", 32'(st), 32'd1);
    idle(3);
    chk(stall_cnt === 16'd3, "dist2_stall_cnt", 32'(stall_cnt), 32'd3);

    // Reset in the first stall cycle clears the in-flight window.
    send(mk(0, 1, 2, 10, 8'h80), st);
    u_in.in_instr = mk(1, 10, 5, 11, 8'h81);
    rst = 1'b1;
    do_cycle(acc);
    rst = 1'b0;
    do_cycle(acc);
    chk(acc == 1'b1, "post_reset_accept", 32'(acc), 32'd1);
    idle(1);
    chk(issue_cnt === 16'd1, "post_reset_issue_cnt", 32'(issue_cnt), 32'd1);
    idle(2);

    // Random traffic with a narrow register range to provoke hazards.
    pend = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (pend && $urandom_range(0, 7) != 0) begin
        u_in.in_valid = 1'b1;
      end else begin
        u_in.in_valid = ($urandom_range(0, 3) != 0);
        u_in.in_instr = mk($urandom_range(0, 15), $urandom_range(0, 5),
                           $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 255));
      end
      rst = ($urandom_range(0, 79) == 0);
      do_cycle(acc);
      pend = u_in.in_valid && !acc;
    end
    rst = 1'b0;
    idle(4);
    chk(q.size() == 0, "queue_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
